// File: rtl/peri_port_arbiter.sv
// peri_port_arbiter: shares the single-port peripheral memory between posted scalar stores and vector bursts.
// Define PERI_ARB_CPU_PRIO_EN for fixed scalar priority; otherwise arbitration is round-robin.
module peri_port_arbiter #(
  parameter int DEPTH = 4,
  parameter int AW    = 16,
  parameter int DW    = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          peri_web_i,
  input  logic [AW-1:0] peri_addr_i,
  input  logic [DW-1:0] peri_datao_i,
  output logic          cpu_stall_o,
  input  logic          vec_req_i,
  input  logic          vec_we_i,
  input  logic [AW-1:0] vec_addr_i,
  input  logic [3:0]    vec_len_i,
  input  logic [DW-1:0] vec_wdata_i,
  output logic          vec_gnt_o,
  output logic          vec_wnext_o,
  output logic          vec_rvalid_o,
  output logic [DW-1:0] vec_rdata_o,
  output logic          vec_done_o,
  output logic          mem_cs_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, CPU_WR, VEC_BURST} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] fifoAddr_q [DEPTH];
  logic [DW-1:0] fifoData_q [DEPTH];
  logic [PW-1:0] wrPtr_q, rdPtr_q;
  logic [PW:0]   count_q, count_d;
  logic [AW-1:0] vAddr_q, vAddr_d;
  logic          vWe_q, vWe_d;
  logic [3:0]    vLen_q, vLen_d;
  logic [3:0]    beat_q, beat_d;
  logic          rdPend_q, rdPend_d;
  logic          done_q, done_d;
  logic          push, pop, cpuPend, cpuWin, vecWin;

  assign cpu_stall_o = (count_q == (PW+1)'(DEPTH));
  assign push        = !peri_web_i && !cpu_stall_o;
  assign cpuPend     = (count_q != '0);

`ifdef PERI_ARB_CPU_PRIO_EN
  assign cpuWin = cpuPend;
  assign vecWin = vec_req_i && !cpuPend;
`else
  // lastVec_q remembers who won the previous arbitration so a tie goes to the other side.
  logic lastVec_q;
  assign cpuWin = cpuPend && (!vec_req_i || lastVec_q);
  assign vecWin = vec_req_i && (!cpuPend || !lastVec_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lastVec_q <= 1'b1;
    end else if (state_q == IDLE && cpuWin) begin
      lastVec_q <= 1'b0;
    end else if (state_q == IDLE && vecWin) begin
      lastVec_q <= 1'b1;
    end
  end
`endif

  always_comb begin
    unique case ({push, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    vAddr_d     = vAddr_q;
    vWe_d       = vWe_q;
    vLen_d      = vLen_q;
    beat_d      = beat_q;
    rdPend_d    = 1'b0;
    done_d      = 1'b0;
    pop         = 1'b0;
    vec_gnt_o   = 1'b0;
    vec_wnext_o = 1'b0;
    mem_cs_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    case (state_q)
      IDLE: begin
        if (cpuWin) begin
          state_d = CPU_WR;
        end else if (vecWin) begin
          vec_gnt_o = 1'b1;
          vAddr_d   = vec_addr_i;
          vWe_d     = vec_we_i;
          vLen_d    = vec_len_i;
          beat_d    = '0;
          state_d   = VEC_BURST;
        end
      end
      CPU_WR: begin
        mem_cs_o    = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = fifoAddr_q[rdPtr_q];
        mem_wdata_o = fifoData_q[rdPtr_q];
        pop         = 1'b1;
        state_d     = IDLE;
      end
      VEC_BURST: begin
        // Address arithmetic wraps naturally at 2^AW; read data returns one cycle later.
        mem_cs_o   = 1'b1;
        mem_we_o   = vWe_q;
        mem_addr_o = vAddr_q + AW'(beat_q);
        if (vWe_q) begin
          mem_wdata_o = vec_wdata_i;
          vec_wnext_o = 1'b1;
        end else begin
          rdPend_d = 1'b1;
        end
        beat_d = beat_q + 4'd1;
        if (beat_q == vLen_q) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      count_q  <= '0;
      wrPtr_q  <= '0;
      rdPtr_q  <= '0;
      vAddr_q  <= '0;
      vWe_q    <= 1'b0;
      vLen_q   <= '0;
      beat_q   <= '0;
      rdPend_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      vAddr_q  <= vAddr_d;
      vWe_q    <= vWe_d;
      vLen_q   <= vLen_d;
      beat_q   <= beat_d;
      rdPend_q <= rdPend_d;
      done_q   <= done_d;
      if (push) wrPtr_q <= wrPtr_q + PW'(1);
      if (pop)  rdPtr_q <= rdPtr_q + PW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !rst_i) begin
      fifoAddr_q[wrPtr_q] <= peri_addr_i;
      fifoData_q[wrPtr_q] <= peri_datao_i;
    end
  end

  assign vec_rvalid_o = rdPend_q;
  assign vec_rdata_o  = rdPend_q ? mem_rdata_i : '0;
  assign vec_done_o   = done_q;

endmodule
